// File: rtl/spi_column_tx.sv
// spi_column_tx: multi-lane SPI word transmitter plus 74HC595 column driver.
// Define SPI_COLUMN_TX_EXTRA_BIT_EN to append I_extra_bit to every word.
module spi_column_tx #(
    parameter int CHANNEL_NUMBER = 8,
    parameter int SPI_SIZE       = 8,
    parameter int CLK_DIV        = 2,
    parameter int MSB_FIRST      = 1,
    parameter int COLUMN_COUNT   = 16
) (
    input  logic                            I_clk,
    input  logic                            I_rst_n,
    input  logic [SPI_SIZE-1:0]             I_data_in [CHANNEL_NUMBER],
    input  logic                            I_next_image,
    input  logic                            I_next_column,
    input  logic                            I_next_data,
    input  logic                            I_extra_bit,
    output logic                            O_tx_finish,
    output logic                            O_busy,
    output logic [$clog2(COLUMN_COUNT)-1:0] O_column,
    output logic                            O_spi_clk,
    output logic [CHANNEL_NUMBER-1:0]       O_spi_mosi,
    output logic                            O_ser_clk,
    output logic                            O_ser_data,
    output logic                            O_ser_stcp,
    output logic                            O_ser_n_enable
);

`ifdef SPI_COLUMN_TX_EXTRA_BIT_EN
    localparam int NB = SPI_SIZE + 1;
`else
    localparam int NB = SPI_SIZE;
`endif
    localparam int CW = $clog2(COLUMN_COUNT);
    localparam int BW = $clog2(SPI_SIZE + 2);
    localparam int DW = $clog2(CLK_DIV + 1);

    localparam logic [BW-1:0] BIT_LAST = BW'(NB - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLUMN_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE, SPI_LO, SPI_HI, SER_LO, SER_HI, LATCH, DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DW-1:0]       r_div;
    logic [BW-1:0]       r_bit;
    logic                r_ser_bit;
    logic                r_is_img;
    logic [CW-1:0]       r_col_tgt;
    logic [CW-1:0]       r_column;
    logic                r_n_enable;
    logic [NB-1:0]       r_shift [CHANNEL_NUMBER];
    logic [NB-1:0]       w_load  [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0] w_mosi;
    logic                w_div_last;
    logic                w_spi_phase;
    logic                w_ser_phase;

`ifndef SPI_COLUMN_TX_EXTRA_BIT_EN
    logic w_unused;
    assign w_unused = I_extra_bit;
`endif

    assign w_div_last = (r_div == DIV_LAST);

    always_comb begin
        for (int l = 0; l < CHANNEL_NUMBER; l++) begin
`ifdef SPI_COLUMN_TX_EXTRA_BIT_EN
            w_load[l] = (MSB_FIRST != 0) ? {I_data_in[l], I_extra_bit}
                                         : {I_extra_bit, I_data_in[l]};
`else
            w_load[l] = I_data_in[l];
`endif
            w_mosi[l] = (MSB_FIRST != 0) ? r_shift[l][NB-1] : r_shift[l][0];
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (I_next_image || I_next_column) begin
                    w_next = SER_LO;
                end else if (I_next_data) begin
                    w_next = SPI_LO;
                end
            end
            SPI_LO: if (w_div_last) w_next = SPI_HI;
            SPI_HI: begin
                if (w_div_last) begin
                    w_next = (r_bit == BIT_LAST) ? DONE : SPI_LO;
                end
            end
            SER_LO: if (w_div_last) w_next = SER_HI;
            SER_HI: if (w_div_last) w_next = LATCH;
            LATCH:  if (w_div_last) w_next = DONE;
            DONE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_div      <= '0;
            r_bit      <= '0;
            r_ser_bit  <= 1'b0;
            r_is_img   <= 1'b0;
            r_col_tgt  <= '0;
            r_column   <= '0;
            r_n_enable <= 1'b1;
            for (int l = 0; l < CHANNEL_NUMBER; l++) begin
                r_shift[l] <= '0;
            end
        end else begin
            if (r_state == IDLE || r_state == DONE || w_div_last) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (r_state == IDLE) begin
                r_bit <= '0;
                if (I_next_image) begin
                    r_is_img  <= 1'b1;
                    r_ser_bit <= 1'b1;
                    r_col_tgt <= '0;
                end else if (I_next_column) begin
                    r_is_img <= 1'b0;
                    // last column wraps and re-injects the select token
                    if (r_column == COL_LAST) begin
                        r_ser_bit <= 1'b1;
                        r_col_tgt <= '0;
                    end else begin
                        r_ser_bit <= 1'b0;
                        r_col_tgt <= r_column + 1'b1;
                    end
                end else if (I_next_data) begin
                    for (int l = 0; l < CHANNEL_NUMBER; l++) begin
                        r_shift[l] <= w_load[l];
                    end
                end
            end

            if (r_state == SPI_HI && w_div_last) begin
                r_bit <= r_bit + 1'b1;
                for (int l = 0; l < CHANNEL_NUMBER; l++) begin
                    r_shift[l] <= (MSB_FIRST != 0) ? (r_shift[l] << 1)
                                                   : (r_shift[l] >> 1);
                end
            end

            if (r_state == LATCH && w_div_last) begin
                r_column <= r_col_tgt;
                if (r_is_img) begin
                    r_n_enable <= 1'b0;
                end
            end
        end
    end

    assign w_spi_phase = (r_state == SPI_LO) || (r_state == SPI_HI);
    assign w_ser_phase = (r_state == SER_LO) || (r_state == SER_HI) ||
                         (r_state == LATCH);

    assign O_busy         = w_spi_phase || w_ser_phase;
    assign O_tx_finish    = (r_state == DONE);
    assign O_spi_clk      = (r_state == SPI_HI);
    assign O_spi_mosi     = w_spi_phase ? w_mosi : '0;
    assign O_ser_clk      = (r_state == SER_HI);
    assign O_ser_stcp     = (r_state == LATCH);
    assign O_ser_data     = w_ser_phase && r_ser_bit;
    assign O_column       = r_column;
    assign O_ser_n_enable = r_n_enable;

endmodule

// File: tb/tb_spi_column_tx.sv
// Testbench for spi_column_tx: two instances (MSB-first/4 columns and
// LSB-first/16 columns) driven in parallel and checked against a scoreboard.
module tb_spi_column_tx;

    localparam int CD  = 2;
`ifdef SPI_COLUMN_TX_EXTRA_BIT_EN
    localparam int NB  = 9;
`else
    localparam int NB  = 8;
`endif
    localparam int CC0 = 4;
    localparam int CC1 = 16;
    localparam int FIN_SER = 1 + 3 * CD;
    localparam int FIN_DAT = 1 + 2 * NB * CD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] data_in [8];
    logic nimg  = 1'b0;
    logic ncol  = 1'b0;
    logic ndat  = 1'b0;
    logic extra = 1'b0;

    logic [1:0] fin, busy, sclk, serclk, serd, stcp, nen;
    logic [1:0][7:0] mosi;
    logic [1:0] col0;
    logic [3:0] col1;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_col [2];
    bit exp_nen [2];
    logic [7:0] mq0 [$];
    logic [7:0] mq1 [$];
    bit cq0 [$];
    bit cq1 [$];

    always #5 clk = ~clk;

    spi_column_tx #(
        .CHANNEL_NUMBER(8), .SPI_SIZE(8), .CLK_DIV(CD),
        .MSB_FIRST(1), .COLUMN_COUNT(CC0)
    ) u_dut0 (
        .I_clk(clk), .I_rst_n(rst_n), .I_data_in(data_in),
        .I_next_image(nimg), .I_next_column(ncol),
        .I_next_data(ndat), .I_extra_bit(extra),
        .O_tx_finish(fin[0]), .O_busy(busy[0]), .O_column(col0),
        .O_spi_clk(sclk[0]), .O_spi_mosi(mosi[0]),
        .O_ser_clk(serclk[0]), .O_ser_data(serd[0]),
        .O_ser_stcp(stcp[0]), .O_ser_n_enable(nen[0])
    );

    spi_column_tx #(
        .CHANNEL_NUMBER(8), .SPI_SIZE(8), .CLK_DIV(CD),
        .MSB_FIRST(0), .COLUMN_COUNT(CC1)
    ) u_dut1 (
        .I_clk(clk), .I_rst_n(rst_n), .I_data_in(data_in),
        .I_next_image(nimg), .I_next_column(ncol),
        .I_next_data(ndat), .I_extra_bit(extra),
        .O_tx_finish(fin[1]), .O_busy(busy[1]), .O_column(col1),
        .O_spi_clk(sclk[1]), .O_spi_mosi(mosi[1]),
        .O_ser_clk(serclk[1]), .O_ser_data(serd[1]),
        .O_ser_stcp(stcp[1]), .O_ser_n_enable(nen[1])
    );

    function automatic logic [3:0] col_of(input int d);
        return (d == 0) ? {2'b00, col0} : col1;
    endfunction

    task automatic push_data();
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < NB; j++) begin
                logic [7:0] v;
                for (int l = 0; l < 8; l++) begin
                    if (j == 8) v[l] = extra;
                    else v[l] = data_in[l][(d == 0) ? 7 - j : j];
                end
                if (d == 0) mq0.push_back(v);
                else mq1.push_back(v);
            end
        end
    endtask

    task automatic model_col(input bit img);
        for (int d = 0; d < 2; d++) begin
            int cc;
            bit sb;
            cc = (d == 0) ? CC0 : CC1;
            if (img) begin
                sb = 1'b1;
                exp_col[d] = 0;
                exp_nen[d] = 1'b0;
            end else if (exp_col[d] == cc - 1) begin
                sb = 1'b1;
                exp_col[d] = 0;
            end else begin
                sb = 1'b0;
                exp_col[d] = exp_col[d] + 1;
            end
            if (d == 0) cq0.push_back(sb);
            else cq1.push_back(sb);
        end
    endtask

    task automatic run_cmd(input bit img, input bit col, input bit dat,
                           input int inj_k, input int exp_fin,
                           input int exp_edges);
        int nfin [2];
        int nspi [2];
        int nser [2];
        int ser_exp;
        logic [1:0] pclk, pser, pstcp, psd;
        logic [1:0][7:0] pmosi;
        ser_exp = (img || col) ? 1 : 0;
        nfin = '{0, 0};
        nspi = '{0, 0};
        nser = '{0, 0};
        pclk = '0; pser = '0; pstcp = '0; psd = '0; pmosi = '0;
        @(negedge clk);
        nimg = img; ncol = col; ndat = dat;
        for (int k = 1; k <= exp_fin + 3; k++) begin
            @(negedge clk);
            nimg = 1'b0; ncol = 1'b0; ndat = (k == inj_k);
            for (int d = 0; d < 2; d++) begin
                if (k == 1) begin
                    n_tests++;
                    if (busy[d] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL busy_rise dut%0d: got %b want 1",
                                 d, busy[d]);
                    end
                end
                if (sclk[d] && !pclk[d]) begin
                    logic [7:0] w;
                    nspi[d]++;
                    n_tests++;
                    if (k != 1 + (2 * nspi[d] - 1) * CD) begin
                        n_fail++;
                        $display("FAIL spi_edge_time dut%0d edge%0d: %0d want %0d",
                                 d, nspi[d], k, 1 + (2 * nspi[d] - 1) * CD);
                    end
                    n_tests++;
                    if ((d == 0 ? mq0.size() : mq1.size()) == 0) begin
                        n_fail++;
                        $display("FAIL spi_extra_edge dut%0d: edge %0d want none",
                                 d, nspi[d]);
                    end else begin
                        if (d == 0) w = mq0.pop_front();
                        else w = mq1.pop_front();
                        if (mosi[d] !== w) begin
                            n_fail++;
                            $display("FAIL mosi_bit dut%0d bit%0d: got %h want %h",
                                     d, nspi[d] - 1, mosi[d], w);
                        end
                    end
                end
                if (sclk[d] && pclk[d]) begin
                    n_tests++;
                    if (mosi[d] !== pmosi[d]) begin
                        n_fail++;
                        $display("FAIL mosi_stable dut%0d: got %h want %h",
                                 d, mosi[d], pmosi[d]);
                    end
                end
                if (serclk[d] && !pser[d]) begin
                    bit sb;
                    nser[d]++;
                    n_tests++;
                    if (k != 1 + CD) begin
                        n_fail++;
                        $display("FAIL ser_clk_time dut%0d: %0d want %0d",
                                 d, k, 1 + CD);
                    end
                    n_tests++;
                    if ((d == 0 ? cq0.size() : cq1.size()) == 0) begin
                        n_fail++;
                        $display("FAIL ser_extra_edge dut%0d: edge seen want none", d);
                    end else begin
                        if (d == 0) sb = cq0.pop_front();
                        else sb = cq1.pop_front();
                        if (serd[d] !== sb) begin
                            n_fail++;
                            $display("FAIL ser_data dut%0d: got %b want %b",
                                     d, serd[d], sb);
                        end
                    end
                end
                if (serclk[d] && pser[d]) begin
                    n_tests++;
                    if (serd[d] !== psd[d]) begin
                        n_fail++;
                        $display("FAIL ser_stable dut%0d: got %b want %b",
                                 d, serd[d], psd[d]);
                    end
                end
                if (stcp[d] && !pstcp[d]) begin
                    n_tests++;
                    if (k != 1 + 2 * CD) begin
                        n_fail++;
                        $display("FAIL stcp_time dut%0d: %0d want %0d",
                                 d, k, 1 + 2 * CD);
                    end
                end
                if (fin[d]) begin
                    nfin[d]++;
                    n_tests++;
                    if (k != exp_fin) begin
                        n_fail++;
                        $display("FAIL finish_time dut%0d: %0d want %0d",
                                 d, k, exp_fin);
                    end
                    n_tests++;
                    if ({busy[d], serd[d], mosi[d]} !== 10'd0) begin
                        n_fail++;
                        $display("FAIL done_outputs dut%0d: busy %b ser %b mosi %h want 0",
                                 d, busy[d], serd[d], mosi[d]);
                    end
                end
                pclk[d] = sclk[d];
                pser[d] = serclk[d];
                pstcp[d] = stcp[d];
                psd[d] = serd[d];
                pmosi[d] = mosi[d];
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (nfin[d] != 1 || nspi[d] != exp_edges || nser[d] != ser_exp) begin
                n_fail++;
                $display("FAIL cmd_counts dut%0d: fin %0d spi %0d ser %0d want 1 %0d %0d",
                         d, nfin[d], nspi[d], nser[d], exp_edges, ser_exp);
            end
            n_tests++;
            if ((d == 0 ? mq0.size() + cq0.size() : mq1.size() + cq1.size()) != 0) begin
                n_fail++;
                $display("FAIL missing_bits dut%0d: leftover expected entries", d);
            end
            n_tests++;
            if (col_of(d) !== 4'(exp_col[d]) || nen[d] !== exp_nen[d] ||
                busy[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL col_state dut%0d: col %0d nen %b busy %b want %0d %b 0",
                         d, col_of(d), nen[d], busy[d], exp_col[d], exp_nen[d]);
            end
        end
        mq0.delete(); mq1.delete(); cq0.delete(); cq1.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_col = '{0, 0};
        exp_nen = '{1'b1, 1'b1};
        repeat (10) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if ({fin[d], busy[d], sclk[d], serclk[d], serd[d], stcp[d], nen[d]}
                    !== 7'b0000001 || mosi[d] !== 8'h00 || col_of(d) !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_idle dut%0d: fbscdtn %b%b%b%b%b%b%b mosi %h col %0d",
                         d, fin[d], busy[d], sclk[d], serclk[d], serd[d], stcp[d],
                         nen[d], mosi[d], col_of(d));
            end
        end
    endtask

    task automatic test_col_before_image();
        model_col(1'b0);
        run_cmd(1'b0, 1'b1, 1'b0, 0, FIN_SER, 0);
        n_tests++;
        if (nen !== 2'b11) begin
            n_fail++;
            $display("FAIL early_col_nen: got %b want 11", nen);
        end
    endtask

    task automatic test_data_msb();
        for (int l = 0; l < 8; l++) data_in[l] = 8'($urandom);
        data_in[0] = 8'hA5;
        data_in[7] = 8'h3C;
        extra = 1'b0;
        push_data();
        run_cmd(1'b0, 1'b0, 1'b1, 0, FIN_DAT, NB);
    endtask

    task automatic test_extra_lsb();
        for (int l = 0; l < 8; l++) data_in[l] = 8'($urandom);
        data_in[0] = 8'h01;
        extra = 1'b1;
        push_data();
        run_cmd(1'b0, 1'b0, 1'b1, 0, FIN_DAT, NB);
        extra = 1'b0;
    endtask

    task automatic test_image_columns();
        model_col(1'b1);
        run_cmd(1'b1, 1'b0, 1'b0, 0, FIN_SER, 0);
        n_tests++;
        if (nen !== 2'b00) begin
            n_fail++;
            $display("FAIL image_nen: got %b want 00", nen);
        end
        for (int i = 0; i < 3; i++) begin
            model_col(1'b0);
            run_cmd(1'b0, 1'b1, 1'b0, 0, FIN_SER, 0);
        end
        n_tests++;
        if (col0 !== 2'd3 || col1 !== 4'd3) begin
            n_fail++;
            $display("FAIL col_three: got %0d %0d want 3 3", col0, col1);
        end
    endtask

    task automatic test_wrap();
        model_col(1'b0);
        run_cmd(1'b0, 1'b1, 1'b0, 0, FIN_SER, 0);
        n_tests++;
        if (col0 !== 2'd0 || col1 !== 4'd4) begin
            n_fail++;
            $display("FAIL col_wrap: got %0d %0d want 0 4", col0, col1);
        end
        model_col(1'b0);
        run_cmd(1'b0, 1'b1, 1'b0, 0, FIN_SER, 0);
    endtask

    task automatic test_collision();
        data_in[0] = 8'hFF;
        model_col(1'b1);
        run_cmd(1'b1, 1'b0, 1'b1, 0, FIN_SER, 0);
    endtask

    task automatic test_busy_drop();
        for (int l = 0; l < 8; l++) data_in[l] = 8'($urandom);
        push_data();
        run_cmd(1'b0, 1'b0, 1'b1, 5, FIN_DAT, NB);
    endtask

    task automatic test_abort();
        int nf;
        nf = 0;
        for (int l = 0; l < 8; l++) data_in[l] = 8'hFF;
        model_col(1'b0);
        run_cmd(1'b0, 1'b1, 1'b0, 0, FIN_SER, 0);
        @(negedge clk);
        ndat = 1'b1;
        @(negedge clk);
        ndat = 1'b0;
        repeat (8) @(negedge clk);
        n_tests++;
        if (busy !== 2'b11 || mosi[0] !== 8'hFF || mosi[1] !== 8'hFF) begin
            n_fail++;
            $display("FAIL abort_midword: busy %b mosi %h %h want 11 ff ff",
                     busy, mosi[0], mosi[1]);
        end
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if ({fin[d], busy[d], sclk[d], serclk[d], serd[d], stcp[d], nen[d]}
                    !== 7'b0000001 || mosi[d] !== 8'h00 || col_of(d) !== 4'd0) begin
                n_fail++;
                $display("FAIL abort_async dut%0d: busy %b sclk %b nen %b mosi %h col %0d",
                         d, busy[d], sclk[d], nen[d], mosi[d], col_of(d));
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (fin !== 2'b00) nf++;
        end
        rst_n = 1'b1;
        exp_col = '{0, 0};
        exp_nen = '{1'b1, 1'b1};
        repeat (4) begin
            @(negedge clk);
            if (fin !== 2'b00 || busy !== 2'b00) nf++;
        end
        n_tests++;
        if (nf != 0) begin
            n_fail++;
            $display("FAIL abort_no_finish: %0d cycles with finish/busy want 0", nf);
        end
    endtask

    initial begin
        for (int l = 0; l < 8; l++) data_in[l] = 8'h00;
        test_reset();
        test_col_before_image();
        test_data_msb();
        test_extra_lsb();
        test_image_columns();
        test_wrap();
        test_collision();
        test_busy_drop();
        test_abort();
        test_data_msb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_column_tx.md
# spi_column_tx

Parametrised multi-channel SPI transmitter with a column-select shift-register driver. It is the next generation of the matrix output stage. It sits after the output sequencer in the `sys_clk_27MHz` domain. Each data command shifts one word out on all channels in parallel. Each column/image command clocks the column-select 74HC595-style shift register. New over the previous stage:
- programmable SPI bit rate;
- selectable bit order;
- column counting with automatic wrap;
- a compile-time extra-bit frame extension.

## Interface
- `CHANNEL_NUMBER`, 8, parallel MOSI lanes.
- `SPI_SIZE`, 8, bits per word per lane.
- `CLK_DIV`, 2, I_clk cycles per SPI/shift half-period (≥1).
- `MSB_FIRST`, 1, 1 = bit SPI_SIZE-1 sent first, 0 = bit 0 first.
- `COLUMN_COUNT`, 16, column-register length (≥2).

Ports:
- `I_clk` in 1: system clock; single clock domain.
- `I_rst_n` in 1: asynchronous, active-low reset.
- `I_data_in` in SPI_SIZE×[CHANNEL_NUMBER] (unpacked): word per lane.
- `I_next_image` in 1: start frame; select column 0.
- `I_next_column` in 1: advance to next column.
- `I_next_data` in 1: transmit one word per lane.
- `I_extra_bit` in 1: bit appended after each word (macro-dependent).
- `O_tx_finish` out 1: one-cycle pulse at command completion.
- `O_busy` out 1: command in progress.
- `O_column` out $clog2(COLUMN_COUNT): currently selected column.
- `O_spi_clk` out 1: shared SPI clock, mode 0 (idle low).
- `O_spi_mosi` out CHANNEL_NUMBER: data lanes.
- `O_ser_clk`, `O_ser_data`, `O_ser_stcp` out 1: shift-register clock, serial in, latch.
- `O_ser_n_enable` out 1: shift-register output enable, active low.

## Operation
- States: IDLE, SPI_LO, SPI_HI, SER_LO, SER_HI, LATCH, DONE.
- Commands are sampled only in IDLE.
  - Priority: next_image > next_column > next_data.
  - Commands arriving while busy are dropped, not queued.
- **Data command:**
  - Latch I_data_in and I_extra_bit into per-lane shift registers.
  - N = SPI_SIZE bits (or SPI_SIZE+1 with the macro).
  - Per bit: SPI_LO for CLK_DIV cycles (MOSI valid, clk low), then SPI_HI for CLK_DIV cycles (clk high).
  - After the last SPI_HI, go to DONE.
- **Image command:** ser_data = 1; column counter target = 0.
- **Column command:**
  - Normal case: ser_data = 0; column target = O_column+1.
  - If O_column == COLUMN_COUNT-1: ser_data = 1, target = 0 (automatic wrap re-injects the token).
- **Column/image sequence:** SER_LO (CLK_DIV) → SER_HI (ser_clk high, CLK_DIV) → LATCH (stcp high, CLK_DIV) → DONE.
  - O_column updates in DONE.
- **DONE:** one cycle; pulses tx_finish, clears busy, MOSI/ser_data return low; then IDLE.
- O_ser_n_enable drops to 0 in DONE of the first image command after reset and stays 0 until reset.
- Column commands before any image command execute normally but leave n_enable high.

## Timing
- Reset values:
  - O_spi_clk, O_spi_mosi, O_ser_clk, O_ser_data, O_ser_stcp, O_tx_finish, O_busy = 0.
  - O_column = 0; O_ser_n_enable = 1.
  - Reset asserted mid-command aborts immediately; no tx_finish is emitted.
- **Data command accepted at cycle T:**
  - O_busy = 1 from T+1.
  - Bit k is on MOSI from T+1+2k·CLK_DIV; rising edge at T+1+(2k+1)·CLK_DIV.
  - tx_finish at T+1+2N·CLK_DIV; next command accepted the following cycle.
- **Column/image command accepted at T:**
  - ser_data valid T+1; ser_clk rises T+1+CLK_DIV; stcp rises T+1+2·CLK_DIV.
  - tx_finish at T+1+3·CLK_DIV.
- MOSI changes only while spi_clk is low. ser_data is stable across the whole ser_clk high phase.
- Bit counter width: $clog2(SPI_SIZE+2). Divider counter width: $clog2(CLK_DIV+1).

## Configuration
- `SPI_COLUMN_TX_EXTRA_BIT_EN`
  - Defined: each word is SPI_SIZE+1 bits; the last bit is the I_extra_bit value latched at acceptance, identical on all lanes.
  - Undefined: words are SPI_SIZE bits and I_extra_bit is ignored. The port remains present.

## Test plan
- **Reset then idle.**
  - Stimulus: reset, then I_rst_n high, then 10 cycles idle.
  - Response: all outputs at reset values; O_ser_n_enable = 1; O_column = 0.
- **Data command, MSB first.**
  - Setup: CLK_DIV=2, MSB_FIRST=1, macro off.
  - Stimulus: lane0=0xA5, lane7=0x3C, next_data at T.
  - Response: lane0 serial 1,0,1,0,0,1,0,1; lane7 serial 0,0,1,1,1,1,0,0; 8 rising edges; tx_finish exactly at T+33.
- **Extra bit, LSB first.**
  - Setup: macro on, MSB_FIRST=0.
  - Stimulus: lane0=0x01, I_extra_bit=1.
  - Response: bits 1,0,0,0,0,0,0,0,1; 9 edges; tx_finish at T+37.
- **Image then columns.**
  - Stimulus: next_image, then 3× next_column.
  - Response: ser_data pattern 1,0,0,0; O_column 0→1→2→3; n_enable low after the first DONE.
- **Column wrap.**
  - Setup: COLUMN_COUNT=4.
  - Stimulus: image plus 4 next_column.
  - Response: 4th column command drives ser_data=1; O_column returns to 0.
- **Collisions and abort.**
  - Stimulus: next_image and next_data in the same cycle → image executes, data is dropped. next_data while busy → ignored, no second tx_finish. I_rst_n low mid-word → outputs reset asynchronously, no tx_finish.
